pipe_stage_reg: RTL

Parametrised pipeline stage register that replaces the fixed, per-stage register modules (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control field and a data field of configurable width, adds a valid/ready handshake for stalls, and provides a synchronous flush that inserts a bubble. A saturating stall counter supports performance debug. It sits between any two adjacent stages of the MIPS datapath.

---
 rtl/pipe_stage_reg.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: ctrl+data travel together, valid/ready handshake, flush, saturating stall counter; 1-cycle latency.
// Backpressure: in_ready = !out_valid || out_ready by default; with PIPE_STAGE_REG_SKID_EN a registered in_ready drops only when both entries are full.
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              accept;
  logic              consume;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign out_ctrl = ctrl_q;
  assign out_data = data_q;
  assign stall_cnt = cnt_q;

`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE: begin
          if (accept && !consume)      state_d = TWO;
          else if (consume && !accept) state_d = EMPTY;
        end
        TWO:     if (consume) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
    // Ready is a flop so out_ready never reaches in_ready combinationally.
    rdy_d = (state_d != TWO);
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = rdy_q || flush;
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      ctrl_d      = '0;
      data_d      = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          ctrl_d = in_ctrl;
          data_d = in_data;
        end
        ONE: begin
          if (accept && consume) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (consume) begin
            ctrl_d = '0;
          end
        end
        TWO: if (consume) begin
          ctrl_d      = skid_ctrl_q;
          data_d      = skid_data_q;
          skid_ctrl_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  logic valid_q, valid_d;

  always_comb begin
    out_valid = valid_q;
    in_ready  = flush || !valid_q || out_ready;
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end else if (consume) begin
      // Bubble must decode as NOP downstream; data is don't-care and held.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)
      cnt_d = '0;
    else if (out_valid && !out_ready && !flush && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
